// File: rtl/foo_pipeline_rv_pkg.sv
// rtl/foo_pipeline_rv_pkg.sv - shared defaults and stage constants for foo_pipeline_rv
//
// Contents:
//   DEFAULT_WIDTH  default data width in bits (2 or more)
//   DEFAULT_DEPTH  default number of register ranks (3 or more)
//   STAGE0_INCR    increment applied by stage 0 to the full word
//   STAGE1_INCR    increment applied by stage 1 to bits [WIDTH-1:1]
package foo_pipeline_rv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 3;

    localparam int STAGE0_INCR = 1;
    localparam int STAGE1_INCR = 1;

endpackage : foo_pipeline_rv_pkg

// File: rtl/foo_pipeline_rv_rank.sv
// rtl/foo_pipeline_rv_rank.sv - one ready/valid register rank of foo_pipeline_rv
//
// Parameters:
//   WIDTH       data width in bits
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset (clears valid)
//   up_valid    upstream valid feeding this rank
//   up_data     upstream data feeding this rank
//   down_ready  ready term of the next rank (or the consumer for the last rank)
//   ready       this rank can take a new item this cycle
//   valid       this rank holds an item
//   data        item held by this rank
// Build option:
//   FOO_PIPELINE_RV_DATA_RESET_EN  when defined the data register also resets to 0
module foo_pipeline_rv_rank
    import foo_pipeline_rv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // An empty rank can always load; a full one only if its item moves on.
    assign ready = ~valid | down_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= up_valid;
        end
    end

`ifdef FOO_PIPELINE_RV_DATA_RESET_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
        end else if (ready && up_valid) begin
            data <= up_data;
        end
    end
`else
    // No reset on data: only the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (ready && up_valid) begin
            data <= up_data;
        end
    end
`endif

endmodule : foo_pipeline_rv_rank

// File: rtl/foo_pipeline_rv.sv
// rtl/foo_pipeline_rv.sv - elastic ready/valid pipeline computing out = x + 3
//
// Parameters:
//   WIDTH      data width in bits (2 or more)
//   DEPTH      number of register ranks (3 or more)
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset; clears every valid bit
//   x          operand
//   in_valid   x is valid this cycle
//   in_ready   x is accepted this cycle (combinational from out_ready)
//   out        result, (x + 3) mod 2^WIDTH
//   out_valid  out is valid this cycle
//   out_ready  consumer accepts out this cycle
// Build option:
//   FOO_PIPELINE_RV_DATA_RESET_EN  when defined data registers reset to 0 as well
//
// Rank 0 captures x, stage 0 (+1 on the full word) sits between ranks 0 and 1,
// stage 1 (+1 on bits [WIDTH-1:1], bit 0 passed through) sits between ranks 1
// and 2; further ranks are pure delay. The last rank drives out/out_valid.
module foo_pipeline_rv
    import foo_pipeline_rv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] rank_data [DEPTH];
    logic [DEPTH-1:0] rank_valid;

    logic [WIDTH-1:0] stage0_sum;
    logic [WIDTH-1:0] stage1_sum;

    // Stage 0: full-word increment.
    assign stage0_sum = rank_data[0] + WIDTH'(STAGE0_INCR);

    // Stage 1: increment the upper WIDTH-1 bits (worth 2 each), keep bit 0.
    assign stage1_sum = {rank_data[1][WIDTH-1:1] + (WIDTH-1)'(STAGE1_INCR),
                         rank_data[1][0]};

    // The ready terms form a combinational chain from out_ready back to
    // in_ready; each rank keeps its own scalar so the chain stays acyclic
    // at the signal level.
    for (genvar k = 0; k < DEPTH; k++) begin : g_rank
        logic             rank_ready;
        logic             down_ready;
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (k == 0) begin : g_capture
            assign up_valid = in_valid;
            assign up_data  = x;
        end else if (k == 1) begin : g_stage0
            assign up_valid = rank_valid[0];
            assign up_data  = stage0_sum;
        end else if (k == 2) begin : g_stage1
            assign up_valid = rank_valid[1];
            assign up_data  = stage1_sum;
        end else begin : g_delay
            assign up_valid = rank_valid[k-1];
            assign up_data  = rank_data[k-1];
        end

        if (k == DEPTH - 1) begin : g_last
            assign down_ready = out_ready;
        end else begin : g_inner
            assign down_ready = g_rank[k+1].rank_ready;
        end

        foo_pipeline_rv_rank #(
            .WIDTH (WIDTH)
        ) u_rank (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .down_ready (down_ready),
            .ready      (rank_ready),
            .valid      (rank_valid[k]),
            .data       (rank_data[k])
        );
    end

    assign in_ready  = g_rank[0].rank_ready;
    assign out       = rank_data[DEPTH-1];
    assign out_valid = rank_valid[DEPTH-1];

endmodule : foo_pipeline_rv
